// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the unified instruction/data memory.
// Shares one memory address port between instruction fetch and load/store,
// sequences the one-cycle registered read response, and rejects misaligned
// data accesses before they reach memory.
module mem_port_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_err,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state;
  logic   resp_is_data;
  logic   last_data;

  logic   aligned;
  logic   grant_d;
  logic   grant_f;
  logic   rd_issue;
  logic   resp_active;

  // Data-side alignment check: words need addr[1:0]=0, halves need addr[0]=0
  always_comb begin
    aligned = 1'b1;
    if (d_funct3[1] && (d_addr[1:0] != 2'b00)) aligned = 1'b0;
    if ((d_funct3[1:0] == 2'b01) && d_addr[0]) aligned = 1'b0;
  end

  // Data wins a tie unless round-robin is on and data won the last grant
  assign grant_d     = rst_n & d_req & (~if_req | (ROUND_ROBIN == 0) | ~last_data);
  assign grant_f     = rst_n & if_req & ~grant_d;
  assign rd_issue    = grant_f | (grant_d & ~d_we & aligned);
  assign resp_active = rst_n & (state == RESP);

  // Issue stage and response pass-through; everything is zero while idle or in reset
  always_comb begin
    if_gnt         = grant_f;
    d_gnt          = grant_d;
    d_err          = grant_d & ~aligned;
    mem_address    = '0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    mem_funct3     = '0;
    mem_read       = resp_active;
    if_rvalid      = resp_active & ~resp_is_data;
    d_rvalid       = resp_active & resp_is_data;
    if_rdata       = '0;
    d_rdata        = '0;
    if (grant_d) begin
      mem_address    = d_addr;
      mem_funct3     = d_funct3;
      mem_write_data = d_wdata;
      mem_write      = d_we & aligned;
    end else if (grant_f) begin
      mem_address = if_addr;
      mem_funct3  = 3'b010;
    end
    if (if_rvalid) if_rdata = mem_read_data;
    if (d_rvalid)  d_rdata  = mem_read_data;
  end

  // Response-stage sequencing and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      resp_is_data <= 1'b0;
      last_data    <= 1'b0;
    end else begin
      state <= rd_issue ? RESP : IDLE;
      if (rd_issue) resp_is_data <= grant_d;
      if (grant_d || grant_f) last_data <= grant_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized requester traffic, checked against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_funct3 = '0;

  logic        if_gnt, if_rvalid, d_gnt, d_err, d_rvalid;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;

  logic        fp_if_gnt, fp_if_rvalid, fp_d_gnt, fp_d_err, fp_d_rvalid;
  logic [31:0] fp_if_rdata, fp_d_rdata, fp_mem_address, fp_mem_write_data;
  logic        fp_mem_read, fp_mem_write;
  logic [2:0]  fp_mem_funct3;
  localparam logic [31:0] FP_RD = 32'h1234_5678;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_err(d_err), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
  );

  mem_port_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(fp_if_gnt), .if_rvalid(fp_if_rvalid), .if_rdata(fp_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(fp_d_gnt), .d_err(fp_d_err), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata),
    .mem_address(fp_mem_address), .mem_read(fp_mem_read), .mem_write(fp_mem_write),
    .mem_write_data(fp_mem_write_data), .mem_funct3(fp_mem_funct3), .mem_read_data(FP_RD)
  );

  // Behavioural 8 kB memory with registered read and byte-lane writes
  logic [31:0] ram [0:2047];
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_funct3[1:0])
        2'b00:   ram[mem_address[12:2]][8*mem_address[1:0] +: 8] <= mem_write_data[7:0];
        2'b01:   ram[mem_address[12:2]][16*mem_address[1] +: 16] <= mem_write_data[15:0];
        default: ram[mem_address[12:2]] <= mem_write_data;
      endcase
    end
    rd_q <= ram[mem_address[12:2]];
  end
  assign mem_read_data = rd_q;

  int tests = 0;
  int fails = 0;

  // Reference model state: who won last, and what response is owed next cycle
  localparam int NONE = 0, FETCH = 1, DATA = 2;
  int          prev_winner;
  int          resp_port;
  logic [31:0] resp_word;
  logic [31:0] ref_mem [0:2047];
  bit          fp_resp_d;
  bit          chk_fp = 1'b0;

  logic        obs_if_gnt, obs_d_gnt, obs_d_err, obs_mem_write, obs_d_rvalid;
  logic [31:0] obs_d_rdata, obs_if_rdata;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    prev_winner = NONE;
    resp_port   = NONE;
    resp_word   = '0;
    fp_resp_d   = 1'b0;
  endfunction

  function automatic bit misaligned(logic [31:0] a, logic [2:0] f3);
    int unsigned sz;
    sz = f3[1] ? 4 : (f3[0] ? 2 : 1);
    return (a % sz) != 0;
  endfunction

  function automatic void ref_store(logic [31:0] a, logic [31:0] wd, logic [2:0] f3);
    int unsigned sz;
    logic [31:0] mask;
    sz   = f3[1] ? 4 : (f3[0] ? 2 : 1);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 1) << (8 * (a % 4)));
    ref_mem[a[12:2]] = (ref_mem[a[12:2]] & ~mask) | ((wd << (8 * (a % 4))) & mask);
  endfunction

  // One clock cycle: predict, sample at the falling edge, compare, advance the model
  task automatic cycle();
    bit g_d, g_f, mis, fp_g_d, fp_g_f;
    logic [31:0] e_addr, e_wd;
    logic [2:0]  e_f3;
    g_d = d_req && (!if_req || prev_winner != DATA);
    g_f = if_req && !g_d;
    mis = g_d && misaligned(d_addr, d_funct3);
    fp_g_d = d_req;
    fp_g_f = if_req && !d_req;
    e_addr = g_d ? d_addr : (g_f ? if_addr : 32'd0);
    e_wd   = g_d ? d_wdata : 32'd0;
    e_f3   = g_d ? d_funct3 : (g_f ? 3'b010 : 3'b000);
    @(negedge clk);
    obs_if_gnt = if_gnt; obs_d_gnt = d_gnt; obs_d_err = d_err; obs_mem_write = mem_write;
    obs_d_rvalid = d_rvalid; obs_d_rdata = d_rdata; obs_if_rdata = if_rdata;
    check("if_gnt", {31'd0, if_gnt}, {31'd0, g_f});
    check("d_gnt", {31'd0, d_gnt}, {31'd0, g_d});
    check("d_err", {31'd0, d_err}, {31'd0, mis});
    check("mem_address", mem_address, e_addr);
    check("mem_write", {31'd0, mem_write}, {31'd0, g_d && d_we && !mis});
    check("mem_write_data", mem_write_data, e_wd);
    check("mem_funct3", {29'd0, mem_funct3}, {29'd0, e_f3});
    check("mem_read", {31'd0, mem_read}, {31'd0, resp_port != NONE});
    check("if_rvalid", {31'd0, if_rvalid}, {31'd0, resp_port == FETCH});
    check("if_rdata", if_rdata, (resp_port == FETCH) ? resp_word : 32'd0);
    check("d_rvalid", {31'd0, d_rvalid}, {31'd0, resp_port == DATA});
    check("d_rdata", d_rdata, (resp_port == DATA) ? resp_word : 32'd0);
    if (chk_fp) begin
      check("fp_d_gnt", {31'd0, fp_d_gnt}, {31'd0, fp_g_d});
      check("fp_if_gnt", {31'd0, fp_if_gnt}, {31'd0, fp_g_f});
      check("fp_d_rdata", fp_d_rdata, fp_resp_d ? FP_RD : 32'd0);
    end
    fp_resp_d = fp_g_d && !d_we && !misaligned(d_addr, d_funct3);
    if (g_d && d_we && !mis) ref_store(d_addr, d_wdata, d_funct3);
    if (g_f) begin
      resp_port = FETCH; resp_word = ref_mem[if_addr[12:2]];
    end else if (g_d && !d_we && !mis) begin
      resp_port = DATA; resp_word = ref_mem[d_addr[12:2]];
    end else begin
      resp_port = NONE; resp_word = '0;
    end
    if (g_d) prev_winner = DATA;
    else if (g_f) prev_winner = FETCH;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(logic [31:0] a);
    bit done = 1'b0;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = obs_if_gnt;
    end
    if_req = 1'b0;
    if (!done) check("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_data(logic we, logic [31:0] a, logic [31:0] wd, logic [2:0] f3);
    bit done = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_funct3 = f3;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = obs_d_gnt;
    end
    d_req = 1'b0;
    if (!done) check("data_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [31:0] v, saved;
    logic [2:0]  f3s [5];
    bit f_pend, d_pend;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    for (int i = 0; i < 2048; i++) begin
      v = $urandom;
      ram[i] <= v;
      ref_mem[i] = v;
    end
    ram[2] <= 32'h0050_0093;      ref_mem[2] = 32'h0050_0093;
    ram[11'h7FF] <= 32'h0;        ref_mem[11'h7FF] = 32'h0;
    model_reset();

    // Outputs held at zero during reset, even with both requests up
    @(posedge clk); #1;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hFFFF_FFFF; d_funct3 = 3'b010;
    #1;
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst_n = 1'b1;

    // Fetch only: instruction returns one cycle after the grant
    do_fetch(32'h8);
    cycle();
    check("fetch_rdata", obs_if_rdata, 32'h0050_0093);

    // Contention after reset: alternating grants, fixed-priority instance always data
    pulse_reset();
    chk_fp = 1'b1;
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("rr_seq%0d", i), {31'd0, obs_d_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    cycle();
    chk_fp = 1'b0;

    // Store then load of the same word, back to back
    do_data(1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010);
    check("st_mem_write", {31'd0, obs_mem_write}, 32'd1);
    do_data(1'b0, 32'h100, 32'h0, 3'b010);
    check("ld_mem_write", {31'd0, obs_mem_write}, 32'd0);
    cycle();
    check("st_ld_rdata", obs_d_rdata, 32'hDEAD_BEEF);

    // Misaligned word store and halfword load are rejected
    saved = ref_mem[11'h40];
    do_data(1'b1, 32'h102, 32'h5555_AAAA, 3'b010);
    check("mis_sw_err", {31'd0, obs_d_err}, 32'd1);
    check("mis_sw_write", {31'd0, obs_mem_write}, 32'd0);
    do_data(1'b0, 32'h101, 32'h0, 3'b001);
    check("mis_lh_err", {31'd0, obs_d_err}, 32'd1);
    cycle();
    check("mis_lh_rvalid", {31'd0, obs_d_rvalid}, 32'd0);
    check("mis_mem_word", ram[11'h40], saved);

    // Peripheral window passes through
    do_data(1'b1, 32'hFFFF_FFFF, 32'h0000_0080, 3'b000);
    do_data(1'b0, 32'hFFFF_FFFC, 32'h0, 3'b010);
    cycle();
    check("periph_rdata", obs_d_rdata, 32'h8000_0000);

    // Reset during a response drops it immediately
    do_fetch(32'h8);
    rst_n = 1'b0;
    #1;
    check("rst_mid_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rst_mid_mem_read", {31'd0, mem_read}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_funct3 = 3'b010;
    cycle();
    check("rst_first_tie_data", {31'd0, obs_d_gnt}, 32'd1);
    if_req = 1'b0; d_req = 1'b0;
    cycle();

    // Random traffic from both requesters
    f_pend = 1'b0; d_pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!f_pend && ($urandom_range(0, 2) != 0)) begin
        f_pend = 1'b1; if_req = 1'b1;
        if_addr = {19'd0, $urandom_range(0, 2047) * 4};
      end
      if (!d_pend && ($urandom_range(0, 2) != 0)) begin
        d_pend = 1'b1; d_req = 1'b1;
        d_we = $urandom_range(0, 1);
        d_funct3 = f3s[$urandom_range(0, 4)];
        d_addr = $urandom_range(0, 8191);
        if ($urandom_range(0, 1) != 0) d_addr[1:0] = 2'b00;
        d_wdata = $urandom;
      end
      cycle();
      if (obs_if_gnt) begin f_pend = 1'b0; if_req = 1'b0; end
      if (obs_d_gnt)  begin d_pend = 1'b0; d_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the unified 8 kB instruction/data memory and its memory-mapped peripherals. It shares the memory's single address port between the CPU instruction-fetch unit and the load/store unit. It accounts for the memory's one-cycle registered read path, including the requirement that mem_read be held high in the cycle after the address is presented. It also rejects misaligned data accesses before they reach memory.

## Interface
- ROUND_ROBIN, 1, 1: alternate grants on contention; 0: data port always wins.
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  reset; asynchronous assert, active-low.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetched instruction; 0 when if_rvalid=0.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata and d_funct3 until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_funct3  in  3  access size/sign (RV32I load/store funct3).
- d_gnt  out  1  data request accepted this cycle.
- d_err  out  1  misaligned access rejected; asserted with d_gnt.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load data; 0 when d_rvalid=0.
- mem_address  out  32  to memory address.
- mem_read  out  1  to memory read enable.
- mem_write  out  1  to memory write enable.
- mem_write_data  out  32  to memory write data.
- mem_funct3  out  3  to memory funct3.
- mem_read_data  in  32  from memory read data.

## Operation
- Pipeline:
  - Issue stage (combinational select).
  - Response stage: state IDLE/RESP, owner flag resp_is_data, and round-robin bit last_data.
- Arbitration in each cycle:
  - Only one requester active: grant it.
  - Both active, ROUND_ROBIN=1: grant data if last_data=0, otherwise grant fetch.
  - Both active, ROUND_ROBIN=0: grant data.
  - last_data updates on every grant (1 for data, 0 for fetch).
- Issue outputs for a granted fetch:
  - mem_address=if_addr, mem_funct3=3'b010, mem_write=0.
- Issue outputs for a granted data request:
  - mem_address=d_addr, mem_funct3=d_funct3, mem_write_data=d_wdata.
  - mem_write=d_we & aligned.
- No grant: mem_address, mem_write_data, mem_funct3 and mem_write are all 0.
- Alignment check (data only):
  - Misaligned when funct3[1]=1 and addr[1:0]≠0.
  - Misaligned when funct3[1:0]=01 and addr[0]=1.
  - A misaligned request gets d_gnt=1 and d_err=1, with no memory write and no response.
  - Fetch is never checked.
- State transitions:
  - Aligned read granted (fetch, or data with d_we=0): next state RESP; owner latched into resp_is_data.
  - Otherwise: next state IDLE.
- In RESP:
  - mem_read=1.
  - The owner's rvalid=1 and its rdata=mem_read_data (combinational pass-through).
  - A new grant may issue in the same cycle, giving back-to-back throughput of 1 access/cycle.
- Stores complete at the clock edge closing the grant cycle; there is no response phase.
- Peripheral addresses (0xFFFFFFF4..0xFFFFFFFF) pass through unchanged.

## Timing
- Reset values: state=IDLE, last_data=0 (first tie goes to data), resp_is_data=0.
  - While rst_n=0, all outputs are 0, including both gnt outputs regardless of req.
- Read latency:
  - Grant in cycle N.
  - Memory captures at the edge ending N.
  - rvalid and rdata valid in cycle N+1.
- A read issued in N+1 right after a store in N to the same word returns the new data.
- A store in N+1 after a read issued in N does not affect the N+1 response.
- gnt is a combinational function of req and state; requesters must not change their fields in a cycle where gnt=0.
- Reset asserted mid-RESP: the response is dropped asynchronously and no rvalid appears after release.
- Simultaneous RESP and new grant: the response belongs to the previous owner and the grant to the new one; both may be the same port.

## Test plan
- Fetch only: if_req=1, if_addr=0x8, mem[2]=0x00500093 -> if_gnt in N, mem_funct3=010, if_rvalid=1 and if_rdata=0x00500093 in N+1.
- Contention after reset: both req held 4 cycles, ROUND_ROBIN=1 -> grants D,F,D,F, each read's rvalid on the correct port one cycle later; repeat with ROUND_ROBIN=0 -> D,D,D,D and if_gnt=0 throughout.
- Store then load: sw 0xDEADBEEF to 0x100 in N, lw 0x100 in N+1 -> mem_write=1 only in N, d_rdata=0xDEADBEEF in N+2.
- Misaligned: d_funct3=010, d_addr=0x102, d_we=1 -> d_gnt=1, d_err=1, mem_write=0, mem[0x40] unchanged; lh at 0x101 -> d_err=1, d_rvalid never asserted.
- Peripheral: sb 0x80 to 0xFFFFFFFF, then lw 0xFFFFFFFC -> d_rdata=0x80000000.
- Reset mid-read: grant a fetch in N, drop rst_n in N+1 before the edge -> if_rvalid=0 and mem_read=0 immediately; after release state=IDLE and the first tie grants data.
